// File: rtl/memory_to_writeback_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mwb_pkg
// Description : Shared constants and types for the MEM->WB pipeline bank.
// Revision    : 1.0 - initial release
// ============================================================================
package mwb_pkg;

  // Result select encodings consumed by the writeback mux
  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam int unsigned REG_ADDR_W = 5;

  // Width-independent per-lane W fields; XLEN-wide data lives in separate arrays
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } mwb_lane_t;

endpackage
`default_nettype wire

// File: rtl/memory_to_writeback_bank_lane_popcount.sv
`default_nettype none
// ============================================================================
// Module      : lane_popcount
// Description : Counts the set bits of a LANES-wide valid vector.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_popcount #(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]             i_lanes,
  output logic [$clog2(LANES+1)-1:0]   o_count
);

  localparam int OUT_W = $clog2(LANES + 1);

  // Ripple sum of the lane bits
  always_comb begin
    o_count = '0;
    for (int i = 0; i < LANES; i++) begin
      o_count = o_count + OUT_W'(i_lanes[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_to_writeback_bank.sv
`default_nettype none
// ============================================================================
// Module      : memory_to_writeback_bank
// Description : LANES-wide MEM->WB pipeline register with stall, flush and
//               intra-bundle same-destination write arbitration (younger,
//               higher-index lane wins). Optional retired-instruction counter
//               enabled by defining MWB_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_to_writeback_bank
  import mwb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallW,
  input  logic                     FlushW,
  input  logic [LANES-1:0]         ValidM,
  input  logic [LANES-1:0]         RegWriteM,
  input  logic [LANES*2-1:0]       ResultSrcM,
  input  logic [LANES*XLEN-1:0]    ALUResultM,
  input  logic [LANES*XLEN-1:0]    ReadDataM,
  input  logic [LANES*5-1:0]       RdM,
  input  logic [LANES*XLEN-1:0]    PCPlus4M,
`ifdef MWB_RETIRE_CNT_EN
  output logic [CNT_W-1:0]         RetireCountW,
`endif
  output logic [LANES-1:0]         ValidW,
  output logic [LANES-1:0]         RegWriteW,
  output logic [LANES*2-1:0]       ResultSrcW,
  output logic [LANES*XLEN-1:0]    ALUResultW,
  output logic [LANES*XLEN-1:0]    ReadDataW,
  output logic [LANES*5-1:0]       RdW,
  output logic [LANES*XLEN-1:0]    PCPlus4W
);

  if (LANES < 1 || CNT_W < 1) begin : g_param_check
    $error("memory_to_writeback_bank: LANES and CNT_W must be at least 1");
  end

  logic [LANES-1:0]            shadowed;
  mwb_lane_t [LANES-1:0]       lane_d, lane_q;
  logic [LANES-1:0][XLEN-1:0]  alu_d, alu_q;
  logic [LANES-1:0][XLEN-1:0]  rdata_d, rdata_q;
  logic [LANES-1:0][XLEN-1:0]  pc4_d, pc4_q;

  // A lane is shadowed when a younger lane in the same bundle writes the same rd
  always_comb begin
    shadowed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (ValidM[j] && RegWriteM[j] &&
            (RdM[j*REG_ADDR_W +: REG_ADDR_W] == RdM[i*REG_ADDR_W +: REG_ADDR_W])) begin
          shadowed[i] = 1'b1;
        end
      end
    end
  end

  // Next-state: flush kills valid/write only, stall holds, otherwise load
  always_comb begin
    lane_d  = lane_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    if (FlushW) begin
      for (int i = 0; i < LANES; i++) begin
        lane_d[i].valid     = 1'b0;
        lane_d[i].reg_write = 1'b0;
      end
    end else if (!StallW) begin
      for (int i = 0; i < LANES; i++) begin
        lane_d[i].valid      = ValidM[i];
        lane_d[i].reg_write  = RegWriteM[i] & ValidM[i] & ~shadowed[i] &
                               (RdM[i*REG_ADDR_W +: REG_ADDR_W] != '0);
        lane_d[i].result_src = ResultSrcM[i*2 +: 2];
        lane_d[i].rd         = RdM[i*REG_ADDR_W +: REG_ADDR_W];
        alu_d[i]             = ALUResultM[i*XLEN +: XLEN];
        rdata_d[i]           = ReadDataM[i*XLEN +: XLEN];
        pc4_d[i]             = PCPlus4M[i*XLEN +: XLEN];
      end
    end
  end

  // Lane register array with synchronous reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst) begin
        lane_q[i]  <= '0;
        alu_q[i]   <= '0;
        rdata_q[i] <= '0;
        pc4_q[i]   <= '0;
      end else begin
        lane_q[i]  <= lane_d[i];
        alu_q[i]   <= alu_d[i];
        rdata_q[i] <= rdata_d[i];
        pc4_q[i]   <= pc4_d[i];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane_out
    assign ValidW[g]                              = lane_q[g].valid;
    assign RegWriteW[g]                           = lane_q[g].reg_write;
    assign ResultSrcW[g*2 +: 2]                   = lane_q[g].result_src;
    assign RdW[g*REG_ADDR_W +: REG_ADDR_W]        = lane_q[g].rd;
    assign ALUResultW[g*XLEN +: XLEN]             = alu_q[g];
    assign ReadDataW[g*XLEN +: XLEN]              = rdata_q[g];
    assign PCPlus4W[g*XLEN +: XLEN]               = pc4_q[g];
  end

`ifdef MWB_RETIRE_CNT_EN
  localparam int POP_W = $clog2(LANES + 1);

  logic [POP_W-1:0] retire_pop;
  logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;

  lane_popcount #(
    .LANES (LANES)
  ) u_lane_popcount (
    .i_lanes (ValidM),
    .o_count (retire_pop)
  );

  // Shadowed lanes still retire, so count raw ValidM on every load edge
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (!FlushW && !StallW) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(retire_pop);
    end
  end

  // Retire counter register, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RetireCountW = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/memory_to_writeback_bank.md
# memory_to_writeback_bank

Parametrised MEM→WB pipeline register bank for the superscalar core. Captures `LANES` parallel memory-stage results per clock and presents them to writeback. Adds per-lane valid tracking, stall and flush control, and intra-bundle same-destination write arbitration. An optional retired-instruction counter can be compiled in.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes; at least 1.
- `XLEN`, 32, datapath width.
- `CNT_W`, 32, retire counter width; used only with `MWB_RETIRE_CNT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `StallW`  in  1  hold all W-stage contents.
- `FlushW`  in  1  invalidate all W-stage lanes.
- `ValidM`  in  LANES  per-lane instruction valid.
- `RegWriteM`  in  LANES  per-lane register write enable.
- `ResultSrcM`  in  LANES×2  per-lane result select: 00 ALU, 01 memory, 10 PC+4.
- `ALUResultM`  in  LANES×XLEN  ALU result.
- `ReadDataM`  in  LANES×XLEN  load data.
- `RdM`  in  LANES×5  destination register.
- `PCPlus4M`  in  LANES×XLEN  link value.
- `ValidW`, `RegWriteW`, `ResultSrcW`, `ALUResultW`, `ReadDataW`, `RdW`, `PCPlus4W`  out  same widths as the M-side ports  registered W-stage copies.
- `RetireCountW`  out  CNT_W  retired-instruction count; present only with `MWB_RETIRE_CNT_EN`.

## Operation
- Priority on each edge: `rst` > `FlushW` > `StallW` > load.
- **rst:** all outputs go to 0, including `RetireCountW`.
- **FlushW:** `ValidW` and `RegWriteW` are cleared to 0.
  - Data fields (`ResultSrcW`, `ALUResultW`, `ReadDataW`, `RdW`, `PCPlus4W`) hold their previous value.
  - Flush wins over a simultaneous stall.
- **StallW (no flush):** every output holds its value.
- **Load:** lane i captures all M-side fields, with:
  - `ValidW[i]` = `ValidM[i]`.
  - `RegWriteW[i]` = `RegWriteM[i] & ValidM[i] & (RdM[i]≠0) & ~shadowed[i]`.
- **Shadowing:** `shadowed[i]` = 1 if any higher-index lane j>i has `ValidM[j]`, `RegWriteM[j]` and `RdM[j]==RdM[i]`.
  - The higher index is the younger instruction and wins.
  - The regfile never sees two writes to the same register in one cycle.
- Writes to x0 are never asserted on `RegWriteW`.
- The block performs no result muxing; writeback consumes `ResultSrcW`.

## Timing
- Latency is 1 cycle from M inputs to W outputs.
- No combinational path from any input to any output.
- Stall is level-sensitive. Holding `StallW` for N cycles freezes outputs for N edges; the first edge with `StallW`=0 loads the then-current M inputs.
- M inputs presented during a stall are not buffered. The upstream stage must hold its inputs while `StallW`=1.
- Reset mid-stall or mid-flush clears everything on that edge. The first load happens on the first edge with `rst`=0.
- The shadowing compare is purely combinational on M inputs before the register. It adds no cycle.

## Configuration
- Macro: `MWB_RETIRE_CNT_EN`.
- **Defined:**
  - `RetireCountW` port and counter exist.
  - On each load edge (`rst`=0, `FlushW`=0, `StallW`=0), the counter adds popcount(`ValidM`).
  - The counter wraps modulo 2^CNT_W.
  - It holds on stall and flush, and resets to 0.
  - Shadowed lanes still count; they retired, they just did not write.
- **Undefined:** no port, no counter logic. All other behaviour is identical.

## Structure
- Package `mwb_pkg`:
  - `RESULT_SRC_ALU`/`MEM`/`PC4` constants (2'b00/01/10).
  - `mwb_lane_t` packed struct holding the per-lane W fields.
- Sub-module `lane_popcount` (parametrised `LANES`, output `$clog2(LANES+1)` bits), instantiated only under the macro.
- The lane register array uses one `always_ff` with a `generate`-style loop. The shadowing mask is a separate `always_comb`.

## Test plan
- **Reset:** assert `rst` with M inputs nonzero → all W outputs 0 next edge; `RetireCountW`=0.
- **Load, LANES=2:** lane0 rd=5 ALU=0x11, lane1 rd=6 ALU=0x22, both valid+RegWrite → next edge `RdW`={6,5}, `RegWriteW`=2'b11, `ValidW`=2'b11; counter +2.
- **Same-rd arbitration:** both lanes write rd=7 → `RegWriteW`=2'b10. Repeat with lane1 `ValidM`=0 → `RegWriteW`=2'b01.
- **x0 suppression:** lane0 `RegWriteM`=1 with rd=0 → `RegWriteW[0]`=0, `ValidW[0]`=1.
- **Stall then flush:**
  - Stall 3 cycles while M inputs change → W outputs frozen, counter unchanged.
  - Then assert `FlushW`+`StallW` together → `ValidW`=0, `RegWriteW`=0, `ALUResultW` unchanged.
- **Counter wrap, CNT_W=4:** 8 cycles of 2 valid lanes → `RetireCountW` goes 0→…→14→0.
